uart_fifo_flex: RTL and testbench

Parametrised synchronous FIFO for the UART datapath, replacing the fixed-flag buffer between the byte deserialiser/serialiser and the host-side register interface. It adds a registered fill level, programmable almost-full/almost-empty thresholds, a synchronous flush, and safe handling of overflow and underflow: illegal accesses are dropped instead of corrupting pointers. Reads are first-word-fall-through.

---
 rtl/uart_fifo_pkg.sv | 12 +
 rtl/uart_fifo_mem.sv | 24 ++
 rtl/uart_fifo_flex.sv | 145 ++++++++++++++
 tb/tb_uart_fifo_flex.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_pkg.sv
// rtl/uart_fifo_pkg.sv - shared defaults and helpers for the UART FIFO
package uart_fifo_pkg;

    localparam int unsigned UART_FIFO_DEPTH_LG2  = 4;
    localparam int unsigned UART_FIFO_DATA_WIDTH = 8;

    // Level must hold 0..depth inclusive, hence depth+1 values.
    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - unreset storage array, one write port, one async read port
module uart_fifo_mem #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_fifo_flex.sv
// rtl/uart_fifo_flex.sv - FWFT UART FIFO with level, thresholds, flush; UART_FIFO_ERR_EN adds sticky ovf/udf
module uart_fifo_flex
    import uart_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LG2  = UART_FIFO_DEPTH_LG2,
    parameter int unsigned DATA_WIDTH = UART_FIFO_DATA_WIDTH,
    parameter int unsigned AF_THRESH  = 12,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  wren_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  full_o,
    output logic                  almost_full_o,
    input  logic                  rden_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  empty_o,
    output logic                  almost_empty_o,
    output logic [level_width(2**DEPTH_LG2)-1:0] level_o
`ifdef UART_FIFO_ERR_EN
    ,
    output logic                  ovf_o,
    output logic                  udf_o,
    input  logic                  err_clr_i
`endif
);

    localparam int unsigned PTR_W = DEPTH_LG2 + 1;
    localparam int unsigned LVL_W = level_width(2**DEPTH_LG2);
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(2**DEPTH_LG2);
    localparam logic [LVL_W-1:0] AF_L    = LVL_W'(AF_THRESH);
    localparam logic [LVL_W-1:0] AE_L    = LVL_W'(AE_THRESH);

    logic [PTR_W-1:0] wrptr_q, wrptr_d, rdptr_q, rdptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             af_q, af_d, ae_q, ae_d;
    logic             wr_acc, rd_acc;

    // Acceptance looks only at registered flags, so a pop never frees room for a same-cycle push.
    assign wr_acc = wren_i & ~full_q;
    assign rd_acc = rden_i & ~empty_q;

    always_comb begin
        wrptr_d = wrptr_q;
        rdptr_d = rdptr_q;
        level_d = level_q;
        if (flush_i) begin
            wrptr_d = '0;
            rdptr_d = '0;
            level_d = '0;
        end else begin
            if (wr_acc) wrptr_d = wrptr_q + PTR_W'(1);
            if (rd_acc) rdptr_d = rdptr_q + PTR_W'(1);
            unique case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
        full_d  = (level_d == DEPTH_L);
        empty_d = (level_d == '0);
        af_d    = (level_d >= AF_L);
        ae_d    = (level_d <= AE_L);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrptr_q <= '0;
            rdptr_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
        end else begin
            wrptr_q <= wrptr_d;
            rdptr_q <= rdptr_d;
            level_q <= level_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
        end
    end

    uart_fifo_mem #(
        .ADDR_WIDTH (DEPTH_LG2),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc & ~flush_i),
        .waddr_i (wrptr_q[DEPTH_LG2-1:0]),
        .wdata_i (wdata_i),
        .raddr_i (rdptr_q[DEPTH_LG2-1:0]),
        .rdata_o (rdata_o)
    );

    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign almost_full_o  = af_q;
    assign almost_empty_o = ae_q;
    assign level_o        = level_q;

`ifdef UART_FIFO_ERR_EN
    logic ovf_q, ovf_d, udf_q, udf_d;

    // Set beats err_clr_i; flush beats both.
    always_comb begin
        ovf_d = ovf_q & ~err_clr_i;
        udf_d = udf_q & ~err_clr_i;
        if (wren_i & full_q)  ovf_d = 1'b1;
        if (rden_i & empty_q) udf_d = 1'b1;
        if (flush_i) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf_o = ovf_q;
    assign udf_o = udf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst_n && !flush_i) begin
            assert (!(wren_i && full_q))
                else $warning("uart_fifo_flex: write dropped, fifo full");
            assert (!(rden_i && empty_q))
                else $warning("uart_fifo_flex: read dropped, fifo empty");
        end
    end

endmodule

// File: tb/tb_uart_fifo_flex.sv
// tb/tb_uart_fifo_flex.sv - directed self-checking bench for uart_fifo_flex (default parameters)
module tb_uart_fifo_flex;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush_i;
    logic       wren_i;
    logic [7:0] wdata_i;
    logic       full_o, almost_full_o;
    logic       rden_i;
    logic [7:0] rdata_o;
    logic       empty_o, almost_empty_o;
    logic [4:0] level_o;
`ifdef UART_FIFO_ERR_EN
    logic       ovf_o, udf_o, err_clr_i;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    uart_fifo_flex dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush_i),
        .wren_i         (wren_i),
        .wdata_i        (wdata_i),
        .full_o         (full_o),
        .almost_full_o  (almost_full_o),
        .rden_i         (rden_i),
        .rdata_o        (rdata_o),
        .empty_o        (empty_o),
        .almost_empty_o (almost_empty_o),
        .level_o        (level_o)
`ifdef UART_FIFO_ERR_EN
        ,
        .ovf_o          (ovf_o),
        .udf_o          (udf_o),
        .err_clr_i      (err_clr_i)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush_i = 1'b0;
        wren_i  = 1'b0;
        rden_i  = 1'b0;
`ifdef UART_FIFO_ERR_EN
        err_clr_i = 1'b0;
`endif
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_full"},  32'(full_o),         32'd0);
        check({tag, "_af"},    32'(almost_full_o),  32'd0);
        check({tag, "_empty"}, 32'(empty_o),        32'd1);
        check({tag, "_ae"},    32'(almost_empty_o), 32'd1);
        check({tag, "_level"}, 32'(level_o),        32'd0);
`ifdef UART_FIFO_ERR_EN
        check({tag, "_ovf"},   32'(ovf_o),          32'd0);
        check({tag, "_udf"},   32'(udf_o),          32'd0);
`endif
    endtask

    initial begin
        rst_n   = 1'b0;
        wdata_i = '0;
        idle();
        tick();
        tick();
        rst_n = 1'b1;
        check_reset_state("reset");

        // Fill with 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            wren_i  = 1'b1;
            wdata_i = 8'(i);
            tick();
            check($sformatf("fill_level_%0d", i), 32'(level_o), 32'(i));
            check($sformatf("fill_af_%0d", i), 32'(almost_full_o), (i >= 12) ? 32'd1 : 32'd0);
            check($sformatf("fill_full_%0d", i), 32'(full_o), (i == 16) ? 32'd1 : 32'd0);
            check($sformatf("fill_head_%0d", i), 32'(rdata_o), 32'h01);
        end
        wdata_i = 8'hFF;
        tick();
        check("ovf_level", 32'(level_o), 32'd16);
        check("ovf_full", 32'(full_o), 32'd1);
`ifdef UART_FIFO_ERR_EN
        check("ovf_flag", 32'(ovf_o), 32'd1);
`endif
        wren_i = 1'b0;

        // Drain: expect 0x01..0x10 in order
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("drain_data_%0d", i), 32'(rdata_o), 32'(i));
            rden_i = 1'b1;
            tick();
            check($sformatf("drain_level_%0d", i), 32'(level_o), 32'(16 - i));
            check($sformatf("drain_ae_%0d", i), 32'(almost_empty_o), (16 - i <= 2) ? 32'd1 : 32'd0);
            check($sformatf("drain_empty_%0d", i), 32'(empty_o), (i == 16) ? 32'd1 : 32'd0);
        end
        tick();
        check("udf_level", 32'(level_o), 32'd0);
        check("udf_empty", 32'(empty_o), 32'd1);
`ifdef UART_FIFO_ERR_EN
        check("udf_flag", 32'(udf_o), 32'd1);
        rden_i = 1'b0;
        err_clr_i = 1'b1;
        tick();
        check("errclr_ovf", 32'(ovf_o), 32'd0);
        check("errclr_udf", 32'(udf_o), 32'd0);
`endif
        idle();

        // Prime to level 5, then 40 cycles of simultaneous push/pop across pointer wrap
        for (int i = 0; i < 5; i++) begin
            wren_i  = 1'b1;
            wdata_i = 8'h20 + 8'(i);
            exp_q.push_back(wdata_i);
            tick();
        end
        check("stream_prime_level", 32'(level_o), 32'd5);
        rden_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wdata_i = 8'h40 + 8'(i);
            check($sformatf("stream_data_%0d", i), 32'(rdata_o), 32'(exp_q.pop_front()));
            exp_q.push_back(wdata_i);
            tick();
            check($sformatf("stream_level_%0d", i), 32'(level_o), 32'd5);
            check($sformatf("stream_flags_%0d", i),
                  {28'd0, full_o, almost_full_o, empty_o, almost_empty_o}, 32'd0);
        end
        wren_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stream_tail_%0d", i), 32'(rdata_o), 32'(exp_q.pop_front()));
            tick();
        end
        check("stream_drained", 32'(empty_o), 32'd1);
        idle();

        // Write into empty with concurrent read: read rejected, write accepted
        wren_i  = 1'b1;
        rden_i  = 1'b1;
        wdata_i = 8'h5A;
        tick();
        idle();
        check("wr_empty_level", 32'(level_o), 32'd1);
        check("wr_empty_data", 32'(rdata_o), 32'h5A);
        check("wr_empty_empty", 32'(empty_o), 32'd0);
`ifdef UART_FIFO_ERR_EN
        check("wr_empty_udf", 32'(udf_o), 32'd1);
`endif

        // Reach level 9 with ovf set, then flush with a concurrent write
        flush_i = 1'b1;
        tick();
        idle();
        check("flush1_level", 32'(level_o), 32'd0);
        wren_i = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wdata_i = 8'h80 + 8'(i);
            tick();
        end
        wren_i = 1'b0;
        rden_i = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        rden_i = 1'b0;
        check("pre_flush_level", 32'(level_o), 32'd9);
        check("pre_flush_head", 32'(rdata_o), 32'h87);
`ifdef UART_FIFO_ERR_EN
        check("pre_flush_ovf", 32'(ovf_o), 32'd1);
`endif
        flush_i = 1'b1;
        wren_i  = 1'b1;
        wdata_i = 8'hEE;
        tick();
        idle();
        check_reset_state("flush");
        tick();
        check("flush_write_discarded", 32'(level_o), 32'd0);

        // Reset at level 7 with concurrent push/pop
        wren_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wdata_i = 8'hA0 + 8'(i);
            tick();
        end
        check("pre_reset_level", 32'(level_o), 32'd7);
        rden_i = 1'b1;
        rst_n  = 1'b0;
        tick();
        idle();
        check_reset_state("midreset");
        rst_n = 1'b1;
        tick();
        check("post_reset_level", 32'(level_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
